window_addr_gen: RTL and testbench

//  Parametrised successor to the 4-column window address sequencer used by the

---
 rtl/window_addr_gen.sv | 109 ++++++++++
 tb/tb_window_addr_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/window_addr_gen.sv
// Round-robin window column address sequencer: NUM_CH channels stepped one per
// cycle, periodic row advance on channels 1..NUM_CH-1, bounded run with Done.
module window_addr_gen #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 8,
  parameter int CH0_BASE   = 15,
  parameter int CHN_BASE   = 0,
  parameter int ROW_PERIOD = 61,
  parameter int ROW_STRIDE = 1,
  parameter int CH0_STEPS  = 240,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Start,
  input  logic                     Stall,
  output logic [NUM_CH*ADDR_W-1:0] Addr,
  output logic [SEL_W-1:0]         ChSel,
  output logic                     AddrValid,
  output logic                     RowAdv,
  output logic                     Busy,
  output logic                     Done,
  output logic [1:0]               dbg_state
);

  localparam int PER_W  = $clog2(ROW_PERIOD);
  localparam int STEP_W = $clog2(CH0_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ch      [NUM_CH];
  logic [ADDR_W-1:0]   ch_next [NUM_CH];
  logic [PER_W-1:0]    period_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                step_en;
  logic                period_hit;

  // Handshake: a step is taken on every edge where AddrValid is high (RUN and
  // not stalled); the stepped value appears on Addr one cycle later. No
  // back-pressure exists beyond Stall, which freezes everything.
  assign step_en    = (state == RUN) && !Stall;
  assign period_hit = (period_cnt == PER_W'(ROW_PERIOD - 1));
  assign AddrValid  = step_en;
  assign RowAdv     = step_en && period_hit;
  assign Busy       = (state == RUN);
  assign Done       = (state == DONE);
  assign dbg_state  = state;

  // Channel step and row advance are additive when both hit the same channel.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_next[k] = ch[k]
                 + ((ChSel == SEL_W'(k)) ? ADDR_W'(1) : ADDR_W'(0))
                 + ((RowAdv && (k != 0)) ? ADDR_W'(ROW_STRIDE) : ADDR_W'(0));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_addr
      assign Addr[g*ADDR_W +: ADDR_W] = ch[g];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      ChSel      <= '0;
      period_cnt <= '0;
      step_cnt   <= '0;
      for (int k = 0; k < NUM_CH; k++)
        ch[k] <= (k == 0) ? ADDR_W'(CH0_BASE) : ADDR_W'(CHN_BASE);
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state      <= RUN;
            ChSel      <= '0;
            period_cnt <= '0;
            step_cnt   <= '0;
            for (int k = 0; k < NUM_CH; k++)
              ch[k] <= (k == 0) ? ADDR_W'(CH0_BASE) : ADDR_W'(CHN_BASE);
          end
        end
        RUN: begin
          if (!Stall) begin
            for (int k = 0; k < NUM_CH; k++)
              ch[k] <= ch_next[k];
            ChSel      <= (ChSel == SEL_W'(NUM_CH - 1)) ? '0 : ChSel + SEL_W'(1);
            period_cnt <= period_hit ? '0 : period_cnt + PER_W'(1);
            if (ChSel == '0) begin
              step_cnt <= step_cnt + STEP_W'(1);
              if (step_cnt == STEP_W'(CH0_STEPS - 1))
                state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_addr_gen.sv
// Directed bench for window_addr_gen: default instance plus short-run and
// near-wrap-base instances, each scenario checked inline against hand values.
module tb_window_addr_gen;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        start_a, start_s, start_b;

  logic [31:0] addr_a, addr_s, addr_b;
  logic [1:0]  sel_a, sel_s, sel_b;
  logic        av_a, av_s, av_b;
  logic        ra_a, ra_s, ra_b;
  logic        busy_a, busy_s, busy_b;
  logic        done_a, done_s, done_b;
  logic [1:0]  st_a, st_s, st_b;

  int n_cmp = 0;
  int n_err = 0;

  window_addr_gen dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start_a), .Stall(stall),
    .Addr(addr_a), .ChSel(sel_a), .AddrValid(av_a), .RowAdv(ra_a),
    .Busy(busy_a), .Done(done_a), .dbg_state(st_a)
  );

  window_addr_gen #(.CH0_STEPS(3)) dut_s (
    .Clk(clk), .Rst_n(rst_n), .Start(start_s), .Stall(stall),
    .Addr(addr_s), .ChSel(sel_s), .AddrValid(av_s), .RowAdv(ra_s),
    .Busy(busy_s), .Done(done_s), .dbg_state(st_s)
  );

  window_addr_gen #(.CH0_BASE(254)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Start(start_b), .Stall(stall),
    .Addr(addr_b), .ChSel(sel_b), .AddrValid(av_b), .RowAdv(ra_b),
    .Busy(busy_b), .Done(done_b), .dbg_state(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0;
    start_a = 1'b0; start_s = 1'b0; start_b = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (addr_a !== {8'd0, 8'd0, 8'd0, 8'd15}) begin n_err++; $display("FAIL reset_addr got %h exp %h", addr_a, {8'd0, 8'd0, 8'd0, 8'd15}); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done_a); end
    n_cmp++; if (sel_a !== 2'd0) begin n_err++; $display("FAIL reset_chsel got %0d exp 0", sel_a); end
    n_cmp++; if (av_a !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", av_a); end
    n_cmp++; if (st_a !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", st_a); end
    n_cmp++; if (addr_b !== {8'd0, 8'd0, 8'd0, 8'd254}) begin n_err++; $display("FAIL reset_addr_b got %h exp %h", addr_b, {8'd0, 8'd0, 8'd0, 8'd254}); end
  endtask

  task automatic test_start();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    #1;
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL start_busy got %b exp 1", busy_a); end
    n_cmp++; if (av_a !== 1'b1) begin n_err++; $display("FAIL start_valid got %b exp 1", av_a); end
    n_cmp++; if (addr_a !== {8'd0, 8'd0, 8'd0, 8'd15}) begin n_err++; $display("FAIL start_addr got %h exp %h", addr_a, {8'd0, 8'd0, 8'd0, 8'd15}); end
    for (int c = 0; c < 4; c++) tick();
    n_cmp++; if (addr_a !== {8'd1, 8'd1, 8'd1, 8'd16}) begin n_err++; $display("FAIL four_steps_addr got %h exp %h", addr_a, {8'd1, 8'd1, 8'd1, 8'd16}); end
    n_cmp++; if (sel_a !== 2'd0) begin n_err++; $display("FAIL four_steps_chsel got %0d exp 0", sel_a); end
  endtask

  // RUN cycles 4..60; RowAdv must be high on cycle 60 only.
  task automatic test_row_adv();
    int bad_cycle;
    bad_cycle = -1;
    for (int c = 4; c <= 60; c++) begin
      if ((ra_a !== (c == 60)) && (bad_cycle < 0)) bad_cycle = c;
      tick();
    end
    n_cmp++; if (bad_cycle >= 0) begin n_err++; $display("FAIL rowadv_timing got wrong RowAdv at run cycle %0d exp high only at 60", bad_cycle); end
    n_cmp++; if (addr_a !== {8'd16, 8'd16, 8'd16, 8'd31}) begin n_err++; $display("FAIL rowadv_addr got %h exp %h", addr_a, {8'd16, 8'd16, 8'd16, 8'd31}); end
    n_cmp++; if (sel_a !== 2'd1) begin n_err++; $display("FAIL rowadv_chsel got %0d exp 1", sel_a); end
  endtask

  task automatic test_stall();
    int bad_cycle;
    tick(); tick();
    n_cmp++; if (addr_a !== {8'd16, 8'd17, 8'd17, 8'd31}) begin n_err++; $display("FAIL prestall_addr got %h exp %h", addr_a, {8'd16, 8'd17, 8'd17, 8'd31}); end
    stall = 1'b1;
    #1;
    n_cmp++; if (av_a !== 1'b0) begin n_err++; $display("FAIL stall_valid got %b exp 0", av_a); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (addr_a !== {8'd16, 8'd17, 8'd17, 8'd31}) begin n_err++; $display("FAIL stall_addr got %h exp %h", addr_a, {8'd16, 8'd17, 8'd17, 8'd31}); end
    n_cmp++; if (sel_a !== 2'd3) begin n_err++; $display("FAIL stall_chsel got %0d exp 3", sel_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL stall_busy got %b exp 1", busy_a); end
    stall = 1'b0;
    #1;
    // Unstalled run cycles resume at 63; next row advance is due on cycle 121.
    bad_cycle = -1;
    for (int c = 63; c <= 121; c++) begin
      if ((ra_a !== (c == 121)) && (bad_cycle < 0)) bad_cycle = c;
      tick();
    end
    n_cmp++; if (bad_cycle >= 0) begin n_err++; $display("FAIL resume_rowadv got wrong RowAdv at run cycle %0d exp high only at 121", bad_cycle); end
    n_cmp++; if (addr_a !== {8'd32, 8'd32, 8'd33, 8'd46}) begin n_err++; $display("FAIL resume_addr got %h exp %h", addr_a, {8'd32, 8'd32, 8'd33, 8'd46}); end
    n_cmp++; if (sel_a !== 2'd2) begin n_err++; $display("FAIL resume_chsel got %0d exp 2", sel_a); end
    // Start while running must not reload.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_cmp++; if (addr_a !== {8'd32, 8'd33, 8'd33, 8'd46}) begin n_err++; $display("FAIL start_in_run got %h exp %h", addr_a, {8'd32, 8'd33, 8'd33, 8'd46}); end
  endtask

  task automatic test_done();
    int early;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    early = 0;
    for (int c = 0; c <= 8; c++) begin
      if (done_s !== 1'b0 || busy_s !== 1'b1) early++;
      tick();
    end
    n_cmp++; if (early != 0) begin n_err++; $display("FAIL done_early got %0d bad cycles exp 0", early); end
    n_cmp++; if (done_s !== 1'b1) begin n_err++; $display("FAIL done_pulse got %b exp 1", done_s); end
    n_cmp++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL done_busy got %b exp 0", busy_s); end
    n_cmp++; if (addr_s !== {8'd2, 8'd2, 8'd2, 8'd18}) begin n_err++; $display("FAIL done_addr got %h exp %h", addr_s, {8'd2, 8'd2, 8'd2, 8'd18}); end
    // Start in DONE is ignored; Done lasts one cycle and addresses hold.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n_cmp++; if (done_s !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got %b exp 0", done_s); end
    n_cmp++; if (st_s !== 2'd0) begin n_err++; $display("FAIL done_to_idle got state %0d exp 0", st_s); end
    n_cmp++; if (addr_s !== {8'd2, 8'd2, 8'd2, 8'd18}) begin n_err++; $display("FAIL idle_hold got %h exp %h", addr_s, {8'd2, 8'd2, 8'd2, 8'd18}); end
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n_cmp++; if (addr_s !== {8'd0, 8'd0, 8'd0, 8'd15}) begin n_err++; $display("FAIL restart_reload got %h exp %h", addr_s, {8'd0, 8'd0, 8'd0, 8'd15}); end
    n_cmp++; if (busy_s !== 1'b1) begin n_err++; $display("FAIL restart_busy got %b exp 1", busy_s); end
  endtask

  task automatic test_wrap_reset();
    int dones;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    n_cmp++; if (addr_b[7:0] !== 8'd255) begin n_err++; $display("FAIL wrap_255 got %0d exp 255", addr_b[7:0]); end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (addr_b !== {8'd1, 8'd1, 8'd1, 8'd0}) begin n_err++; $display("FAIL wrap_zero got %h exp %h", addr_b, {8'd1, 8'd1, 8'd1, 8'd0}); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", busy_b); end
    n_cmp++; if (addr_b !== {8'd0, 8'd0, 8'd0, 8'd254}) begin n_err++; $display("FAIL abort_addr got %h exp %h", addr_b, {8'd0, 8'd0, 8'd0, 8'd254}); end
    n_cmp++; if (sel_b !== 2'd0) begin n_err++; $display("FAIL abort_chsel got %0d exp 0", sel_b); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_b !== 1'b0) dones++;
      tick();
    end
    n_cmp++; if (dones != 0) begin n_err++; $display("FAIL abort_no_done got %0d Done cycles exp 0", dones); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_row_adv();
    test_stall();
    test_done();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
